// File: rtl/serial_add_pkg.sv
// Shared FSM encoding for the bit-serial adder sequencer.
package serial_add_pkg;
   localparam int STATE_W = 2;
   typedef logic [STATE_W-1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t SHIFT = 2'd1;
   localparam state_t DONE  = 2'd2;
endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder built from two half adders; the arithmetic core of serial_add_ctrl.
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic s0, c0, c1;

   half_adder u_ha0 (.x(a),  .y(b),  .s(s0), .c(c0));
   half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

   assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder with valid/ready on both sides; LSB-first through one full adder.
// Define SERIAL_ADD_SUB_EN to add the sub port (subtract via ~b with carry-in 1).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic         sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         carry_out,
   output logic         busy
);
   localparam int CNT_W = $clog2(W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

   state_t           state;
   logic [W-1:0]     a_sr, b_sr, res_sr, res_nxt;
   logic [CNT_W-1:0] cnt;
   logic             c;
   logic             fa_s, fa_co;

   full_adder_cell u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (c),
      .s  (fa_s),
      .co (fa_co)
   );

   // NOTE: default first, then override the MSB -- every path assigns, so no latch.
   always_comb begin
      res_nxt        = res_sr >> 1;
      res_nxt[W-1]   = fa_s;
   end

   // NOTE: sequential state uses <= only so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         cnt       <= '0;
         c         <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
`ifdef SERIAL_ADD_SUB_EN
                  b_sr  <= sub ? ~b : b;
                  c     <= sub;
`else
                  b_sr  <= b;
                  c     <= 1'b0;
`endif
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_nxt;
               c      <= fa_co;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  sum       <= res_nxt;
                  carry_out <= fa_co;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
endmodule
